rsa_core_modx: RTL and testbench
================================

// Module: rsa_core_modx
// PURPOSE
//  Multi-mode modular arithmetic core for the RSA datapath. Mode 0 reduces a wide operand (A mod N).
//  Mode 1 computes an interleaved modular product ((X*Y) mod N), the building block of modular exponentiation.
//  Latency is fixed per mode, one bit per clock. The block sits between the exponentiation sequencer and
//  the operand registers.
// PARAMETERS
//  DATA_WIDTH  8             width of N, X, Y and the result
//  A_WIDTH     2*DATA_WIDTH  width of the mode-0 dividend A (must be >= DATA_WIDTH)
// PORTS
//  mod_clk    in   1           clock, rising edge
//  mod_rst    in   1           reset, asynchronous, active-high
//  mod_start  in   1           request; sampled only when mod_busy=0
//  mod_op     in   1           0: A mod N; 1: (X*Y) mod N; captured with mod_start
//  mod_a      in   A_WIDTH     mode-0 dividend
//  mod_x      in   DATA_WIDTH  mode-1 multiplicand (must be < N)
//  mod_y      in   DATA_WIDTH  mode-1 multiplier
//  mod_n      in   DATA_WIDTH  modulus
//  mod_busy   out  1           high from the cycle after start acceptance until the result is issued
//  mod_done   out  1           one-cycle completion pulse (also on error)
//  mod_err    out  1           error flag, valid with mod_done, held until next accepted start
//  mod_c      out  DATA_WIDTH  result, held until next completion
//  mod_q      out  A_WIDTH     quotient (only with RSA_MOD_QUOT_EN)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): state=IDLE.
//    mod_busy=0, mod_done=0, mod_err=0, mod_c=0, mod_q=0. The in-flight job is discarded.
//  - FSM IDLE->CHECK->RUN->DONE->IDLE. Errors take CHECK->ERROR->IDLE. All outputs are registered.
//  - IDLE: at edge E0 with mod_start=1, latch mod_op, mod_a, mod_x, mod_y and mod_n.
//    Also clear R (DATA_WIDTH+1 bits) and load bit counter K: A_WIDTH (op 0) or DATA_WIDTH (op 1).
//    mod_err is cleared at E0. mod_start while busy is ignored; no queueing.
//  - CHECK (1 cycle): error if N==0, or if op=1 and X>=N. Otherwise go to RUN.
//  - RUN, one bit per edge, MSB first:
//      op 0: R=2R+a[i]; if R>=N: R-=N.
//      op 1: R=2R; if R>=N: R-=N. Then if y[i]: R+=X; if R>=N: R-=N (both combinational in one cycle).
//    Counter decrements per edge; exit RUN when it reaches 0. No intermediate exceeds 2N-1.
//  - DONE/ERROR -> IDLE on the next edge, registering the outputs:
//    mod_done=1 for exactly one cycle, mod_busy=0.
//    Normal completion: mod_c=R[DATA_WIDTH-1:0], mod_err=0.
//    Error: mod_c=all ones, mod_err=1.
//  - Timing, with E0 the acceptance edge: mod_done is high after edge E0+K+3 (normal) or E0+3 (error).
//    mod_busy is high after E0 through the edge that raises mod_done.
//  - Back-to-back: mod_start high during the mod_done cycle is accepted (state is already IDLE).
//  - Inputs other than mod_start/mod_op are don't-care after E0.
// CONFIGURATION
//  RSA_MOD_QUOT_EN defined: port mod_q exists.
//    op 0: bit i = 1 iff the RUN step for a[i] subtracted N (mod_q = A div N).
//    op 1: mod_q=0. Error: mod_q=all ones. Updated and held like mod_c.
//  RSA_MOD_QUOT_EN undefined: mod_q port and quotient register are absent; all other behaviour is identical.
// TESTING (DATA_WIDTH=8, A_WIDTH=16)
//  op0 A=1000 N=7 -> done at E0+19, c=6, err=0, q=142 (with RSA_MOD_QUOT_EN).
//  op0 A=65535 N=255 -> c=0, q=257. op0 A=5 N=200 -> c=5, q=0.
//  op1 X=13 Y=11 N=17 -> done at E0+11, c=7. op1 X=0 Y=255 N=1 -> c=0.
//  N=0 (either op) or op1 X=20 N=17 -> done at E0+3, err=1, c=0xFF. Next valid job clears err at its E0.
//  Start pulsed while busy -> ignored; start during the done cycle -> accepted and correct second result.
//  mod_rst asserted mid-RUN -> outputs 0 immediately; fresh job afterwards gives correct result.

Source files
------------

// File: rtl/rsa_core_modx.sv
// Multi-mode modular arithmetic core: op 0 computes A mod N, op 1 computes (X*Y) mod N, one bit per clock.
// Optional quotient output mod_q is enabled by defining RSA_MOD_QUOT_EN.
module rsa_core_modx #(
    parameter int DATA_WIDTH = 8,
    parameter int A_WIDTH    = 2 * DATA_WIDTH
) (
    input  logic                  mod_clk,
    input  logic                  mod_rst,
    input  logic                  mod_start,
    input  logic                  mod_op,
    input  logic [A_WIDTH-1:0]    mod_a,
    input  logic [DATA_WIDTH-1:0] mod_x,
    input  logic [DATA_WIDTH-1:0] mod_y,
    input  logic [DATA_WIDTH-1:0] mod_n,
    output logic                  mod_busy,
    output logic                  mod_done,
    output logic                  mod_err,
`ifdef RSA_MOD_QUOT_EN
    output logic [A_WIDTH-1:0]    mod_q,
`endif
    output logic [DATA_WIDTH-1:0] mod_c
);

    localparam int CW = $clog2(A_WIDTH + 1);
    localparam int RW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  op_r;
    logic [A_WIDTH-1:0]    a_r;
    logic [DATA_WIDTH-1:0] x_r;
    logic [DATA_WIDTH-1:0] y_r;
    logic [DATA_WIDTH-1:0] n_r;
    logic [DATA_WIDTH:0]   r_r;
    logic [CW-1:0]         cnt_r;
    logic                  fin_r;
    logic                  fin_err_r;
`ifdef RSA_MOD_QUOT_EN
    logic [A_WIDTH-1:0]    q_r;
`endif

    logic                  accept_s;
    logic                  bad_s;
    logic [RW-1:0]         dbl_s;
    logic [RW-1:0]         red1_s;
    logic [RW-1:0]         add_s;
    logic [RW-1:0]         red2_s;
    logic                  sub1_s;
    logic [DATA_WIDTH:0]   r_nxt_s;

    assign accept_s = (state_r == ST_IDLE) && !mod_busy && mod_start;

    // Operand checks and one reduction step; a_r/y_r shift left so the current bit is always the MSB.
    always_comb begin
        bad_s   = (n_r == {DATA_WIDTH{1'b0}}) || (op_r && (x_r >= n_r));
        dbl_s   = {r_r, 1'b0} + {{(RW-1){1'b0}}, (!op_r && a_r[A_WIDTH-1])};
        sub1_s  = (dbl_s >= {2'b00, n_r});
        if (sub1_s) begin
            red1_s = dbl_s - {2'b00, n_r};
        end else begin
            red1_s = dbl_s;
        end
        add_s = red1_s + {2'b00, x_r};
        if (add_s >= {2'b00, n_r}) begin
            red2_s = add_s - {2'b00, n_r};
        end else begin
            red2_s = add_s;
        end
        if (op_r && y_r[DATA_WIDTH-1]) begin
            r_nxt_s = red2_s[DATA_WIDTH:0];
        end else begin
            r_nxt_s = red1_s[DATA_WIDTH:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (bad_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ERROR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge mod_clk or posedge mod_rst) begin
        if (mod_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture and the bit-serial datapath.
    always_ff @(posedge mod_clk or posedge mod_rst) begin
        if (mod_rst) begin
            op_r  <= 1'b0;
            a_r   <= {A_WIDTH{1'b0}};
            x_r   <= {DATA_WIDTH{1'b0}};
            y_r   <= {DATA_WIDTH{1'b0}};
            n_r   <= {DATA_WIDTH{1'b0}};
            r_r   <= {(DATA_WIDTH+1){1'b0}};
            cnt_r <= {CW{1'b0}};
`ifdef RSA_MOD_QUOT_EN
            q_r   <= {A_WIDTH{1'b0}};
`endif
        end else if (accept_s) begin
            op_r  <= mod_op;
            a_r   <= mod_a;
            x_r   <= mod_x;
            y_r   <= mod_y;
            n_r   <= mod_n;
            r_r   <= {(DATA_WIDTH+1){1'b0}};
            cnt_r <= mod_op ? CW'(DATA_WIDTH) : CW'(A_WIDTH);
`ifdef RSA_MOD_QUOT_EN
            q_r   <= {A_WIDTH{1'b0}};
`endif
        end else if (state_r == ST_RUN) begin
            r_r   <= r_nxt_s;
            cnt_r <= cnt_r - CW'(1);
            a_r   <= a_r << 1;
            y_r   <= y_r << 1;
`ifdef RSA_MOD_QUOT_EN
            q_r   <= (q_r << 1) | {{(A_WIDTH-1){1'b0}}, (sub1_s && !op_r)};
`endif
        end else begin
            r_r   <= r_r;
        end
    end

    // Output registers; results are issued one edge after leaving DONE/ERROR.
    always_ff @(posedge mod_clk or posedge mod_rst) begin
        if (mod_rst) begin
            fin_r     <= 1'b0;
            fin_err_r <= 1'b0;
            mod_busy  <= 1'b0;
            mod_done  <= 1'b0;
            mod_err   <= 1'b0;
            mod_c     <= {DATA_WIDTH{1'b0}};
`ifdef RSA_MOD_QUOT_EN
            mod_q     <= {A_WIDTH{1'b0}};
`endif
        end else begin
            fin_r     <= (state_r == ST_DONE) || (state_r == ST_ERROR);
            fin_err_r <= (state_r == ST_ERROR);
            mod_done  <= fin_r;
            if (accept_s) begin
                mod_busy <= 1'b1;
                mod_err  <= 1'b0;
            end else if (fin_r) begin
                mod_busy <= 1'b0;
                mod_err  <= fin_err_r;
                mod_c    <= fin_err_r ? {DATA_WIDTH{1'b1}} : r_r[DATA_WIDTH-1:0];
`ifdef RSA_MOD_QUOT_EN
                mod_q    <= fin_err_r ? {A_WIDTH{1'b1}} : (op_r ? {A_WIDTH{1'b0}} : q_r);
`endif
            end else begin
                mod_busy <= mod_busy;
            end
        end
    end

endmodule

// File: tb/tb_rsa_core_modx.sv
// Scoreboard testbench for rsa_core_modx (DATA_WIDTH=8, A_WIDTH=16); checks mod_q when RSA_MOD_QUOT_EN is defined.
module tb_rsa_core_modx;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          mod_clk = 1'b0;
    logic          mod_rst = 1'b1;
    logic          mod_start = 1'b0;
    logic          mod_op = 1'b0;
    logic [AW-1:0] mod_a = '0;
    logic [DW-1:0] mod_x = '0;
    logic [DW-1:0] mod_y = '0;
    logic [DW-1:0] mod_n = '0;
    logic          mod_busy;
    logic          mod_done;
    logic          mod_err;
    logic [DW-1:0] mod_c;
    logic [AW-1:0] mod_q;

    typedef struct {
        logic [DW-1:0] c;
        logic          err;
        logic [AW-1:0] q;
        int            e0;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    rsa_core_modx #(.DATA_WIDTH(DW), .A_WIDTH(AW)) dut (
        .mod_clk   (mod_clk),
        .mod_rst   (mod_rst),
        .mod_start (mod_start),
        .mod_op    (mod_op),
        .mod_a     (mod_a),
        .mod_x     (mod_x),
        .mod_y     (mod_y),
        .mod_n     (mod_n),
        .mod_busy  (mod_busy),
        .mod_done  (mod_done),
        .mod_err   (mod_err),
`ifdef RSA_MOD_QUOT_EN
        .mod_q     (mod_q),
`endif
        .mod_c     (mod_c)
    );

`ifndef RSA_MOD_QUOT_EN
    assign mod_q = '0;
`endif

    always #5 mod_clk = ~mod_clk;

    always @(posedge mod_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every completion against the oldest scoreboard entry.
    always @(negedge mod_clk) begin
        if (!mod_rst && mod_done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result_c", 32'(mod_c), 32'(e.c));
                check_val("result_err", 32'(mod_err), 32'(e.err));
                check_val("latency", 32'(cyc - e.e0 - 1), 32'(e.lat));
                check_val("busy_at_done", 32'(mod_busy), 32'd0);
`ifdef RSA_MOD_QUOT_EN
                check_val("result_q", 32'(mod_q), 32'(e.q));
`endif
            end
        end
    end

    task automatic run_job(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] x,
                           input logic [DW-1:0] y, input logic [DW-1:0] n);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge mod_clk);
        while (mod_busy && guard < 200) begin
            @(negedge mod_clk);
            guard++;
        end
        if (guard >= 200) check_val("idle_timeout", 32'd1, 32'd0);
        if (n == 0 || (op && x >= n)) begin
            e.c = 8'hFF; e.err = 1'b1; e.q = 16'hFFFF; e.lat = 3;
        end else if (!op) begin
            e.c = DW'(int'(a) % int'(n)); e.err = 1'b0; e.q = AW'(int'(a) / int'(n)); e.lat = AW + 3;
        end else begin
            e.c = DW'((int'(x) * int'(y)) % int'(n)); e.err = 1'b0; e.q = '0; e.lat = DW + 3;
        end
        e.e0 = cyc;
        sb.push_back(e);
        mod_start = 1'b1; mod_op = op; mod_a = a; mod_x = x; mod_y = y; mod_n = n;
        @(negedge mod_clk);
        mod_start = 1'b0;
        mod_a = AW'($urandom); mod_x = DW'($urandom); mod_y = DW'($urandom); mod_n = DW'($urandom);
        check_val("busy_after_e0", 32'(mod_busy), 32'd1);
        check_val("err_clear_e0", 32'(mod_err), 32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge mod_clk);
            guard++;
        end
        if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #12;
        check_val("rst_busy", 32'(mod_busy), 32'd0);
        check_val("rst_done", 32'(mod_done), 32'd0);
        check_val("rst_err", 32'(mod_err), 32'd0);
        check_val("rst_c", 32'(mod_c), 32'd0);
        check_val("rst_q", 32'(mod_q), 32'd0);
        @(negedge mod_clk);
        mod_rst = 1'b0;

        run_job(1'b0, 16'd1000, 8'd0, 8'd0, 8'd7);
        run_job(1'b0, 16'd65535, 8'd0, 8'd0, 8'd255);
        run_job(1'b0, 16'd5, 8'd0, 8'd0, 8'd200);
        run_job(1'b1, 16'd0, 8'd13, 8'd11, 8'd17);
        run_job(1'b1, 16'd0, 8'd0, 8'd255, 8'd1);
        run_job(1'b0, 16'd1234, 8'd0, 8'd0, 8'd0);
        run_job(1'b1, 16'd0, 8'd3, 8'd4, 8'd0);
        run_job(1'b1, 16'd0, 8'd20, 8'd5, 8'd17);
        run_job(1'b1, 16'd0, 8'd254, 8'd255, 8'd255);
        drain();

        // A start pulse while busy must be ignored.
        run_job(1'b0, 16'd40000, 8'd0, 8'd0, 8'd9);
        repeat (4) @(negedge mod_clk);
        mod_start = 1'b1; mod_op = 1'b1; mod_x = 8'd1; mod_y = 8'd1; mod_n = 8'd0;
        @(negedge mod_clk);
        mod_start = 1'b0;
        drain();

        // Asynchronous reset in the middle of RUN discards the job.
        run_job(1'b0, 16'd54321, 8'd0, 8'd0, 8'd13);
        repeat (6) @(negedge mod_clk);
        mod_rst = 1'b1;
        #1;
        check_val("midrst_busy", 32'(mod_busy), 32'd0);
        check_val("midrst_done", 32'(mod_done), 32'd0);
        check_val("midrst_c", 32'(mod_c), 32'd0);
        check_val("midrst_err", 32'(mod_err), 32'd0);
        sb.delete();
        @(negedge mod_clk);
        mod_rst = 1'b0;
        run_job(1'b1, 16'd0, 8'd100, 8'd200, 8'd251);

        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] n;
            n = DW'($urandom_range(1, 255));
            if (i[0]) run_job(1'b1, 16'd0, DW'($urandom_range(0, int'(n) - 1)), DW'($urandom), n);
            else      run_job(1'b0, AW'($urandom), 8'd0, 8'd0, n);
        end
        drain();
        repeat (3) @(negedge mod_clk);
        check_val("idle_done_low", 32'(mod_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
